// File: rtl/adder_req_ctrl.sv
// ---------------------------------------------------------------------------
// adder_req_ctrl
//
// Request-side controller for the 8-bit adder's Data_val/Data_ready
// handshake. The block takes one operand pair from an upstream valid/ready
// source and presents it to the adder. It strobes Data_val for a single
// cycle and waits a bounded number of cycles for Data_ready. It then checks
// the returned {carry, sum} against its own expected sum and holds the
// checked result for a downstream valid/ready consumer. Two saturating
// counters track completed transactions and failed ones (mismatch or
// timeout).
//
// Parameters
//   DATA_W   operand / sum width (must match the adder)
//   TIMEOUT  WAIT cycles without Data_ready before giving up (>= 1)
//   CNT_W    width of txn_count / err_count
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   op_valid     upstream operand pair valid
//   op_ready     controller can accept an operand pair (IDLE only)
//   op_a, op_b   operands from upstream
//   Value_a/b    operands held towards the adder
//   Data_val     one-cycle request strobe to the adder
//   Sum_result   sum returned by the adder
//   Sum_carry    carry returned by the adder
//   Data_ready   adder result valid
//   res_valid    checked result available (RESP state)
//   res_ready    downstream consumes the result
//   res_sum      captured Sum_result (0 on timeout)
//   res_carry    captured Sum_carry  (0 on timeout)
//   res_err      captured {carry, sum} differed from the expected value
//   res_timeout  adder did not answer within TIMEOUT WAIT cycles
//   txn_count    consumed transactions, saturating
//   err_count    consumed transactions with res_err or res_timeout, saturating
// ---------------------------------------------------------------------------
module adder_req_ctrl #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,

    // upstream operand source
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,

    // adder request / response
    output logic [DATA_W-1:0] Value_a,
    output logic [DATA_W-1:0] Value_b,
    output logic              Data_val,
    input  logic [DATA_W-1:0] Sum_result,
    input  logic              Sum_carry,
    input  logic              Data_ready,

    // downstream checked result
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_carry,
    output logic              res_err,
    output logic              res_timeout,

    // statistics
    output logic [CNT_W-1:0]  txn_count,
    output logic [CNT_W-1:0]  err_count
);

    // Timer only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W:0]  expected;
    logic [TMR_W-1:0] timer;

    // Qualified events, all decoded from the current state.
    logic accept;
    logic got_rsp;
    logic timed_out;
    logic consume;

    assign accept    = (state == S_IDLE) && op_valid;
    assign got_rsp   = (state == S_WAIT) && Data_ready;
    // Data_ready takes priority over an expiring timer in the same cycle.
    assign timed_out = (state == S_WAIT) && !Data_ready && (timer == TMR_LAST);
    assign consume   = (state == S_RESP) && res_ready;

    // Handshake outputs are pure state decodes, so no input reaches an output
    // combinationally.
    assign op_ready  = (state == S_IDLE);
    assign Data_val  = (state == S_DRIVE);
    assign res_valid = (state == S_RESP);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values of the others, independent of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so every path assigns
    // it; a missing assignment here would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept)               state_nxt = S_DRIVE;
            S_DRIVE:                           state_nxt = S_WAIT;
            S_WAIT:  if (got_rsp || timed_out) state_nxt = S_RESP;
            S_RESP:  if (consume)              state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand and expected-sum capture. Value_a/Value_b hold their last
    // values between transactions and change only on a new accept.
    // -----------------------------------------------------------------------
    // NOTE: these are a handful of flops, not a memory, so they are cleared by
    // reset like everything else; an abandoned transaction leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Value_a  <= '0;
            Value_b  <= '0;
            expected <= '0;
        end else if (accept) begin
            Value_a  <= op_a;
            Value_b  <= op_b;
            // Zero-extend before adding so the carry lands in bit DATA_W.
            expected <= {1'b0, op_a} + {1'b0, op_b};
        end
    end

    // -----------------------------------------------------------------------
    // Response timer: cleared in DRIVE, counts WAIT cycles without Data_ready.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == S_DRIVE) begin
            timer <= '0;
        end else if ((state == S_WAIT) && !Data_ready && !timed_out) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Result capture. Fields are written only when leaving WAIT, so they stay
    // stable for the whole RESP period regardless of res_ready.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_sum     <= '0;
            res_carry   <= 1'b0;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
        end else if (got_rsp) begin
            res_sum     <= Sum_result;
            res_carry   <= Sum_carry;
            res_err     <= ({Sum_carry, Sum_result} != expected);
            res_timeout <= 1'b0;
        end else if (timed_out) begin
            res_sum     <= '0;
            res_carry   <= 1'b0;
            res_err     <= 1'b0;
            res_timeout <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics: updated once, when the downstream consumes the result.
    // An abandoned (reset) transaction never reaches RESP and is not counted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (consume) begin
            if (txn_count != CNT_MAX) begin
                txn_count <= txn_count + CNT_W'(1);
            end
            if ((res_err || res_timeout) && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_adder_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_req_ctrl
//
// Directed bench for adder_req_ctrl. A behavioural adder answers each
// Data_val pulse after a programmable delay (or never) and can add a fixed
// error to its result. Expected values below are worked out by hand.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_adder_req_ctrl;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] Value_a;
    logic [7:0] Value_b;
    logic       Data_val;
    logic [7:0] Sum_result;
    logic       Sum_carry;
    logic       Data_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_sum;
    logic       res_carry;
    logic       res_err;
    logic       res_timeout;
    logic [15:0] txn_count;
    logic [15:0] err_count;

    int n_vec  = 0;
    int n_miss = 0;

    // adder model controls: delay in cycles after the first possible answer,
    // negative means never answer; fault_add corrupts the returned sum
    int       rsp_delay = 0;
    logic [8:0] fault_add = '0;
    int       dv_count  = 0;

    adder_req_ctrl #(
        .DATA_W  (8),
        .TIMEOUT (4),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .Value_a     (Value_a),
        .Value_b     (Value_b),
        .Data_val    (Data_val),
        .Sum_result  (Sum_result),
        .Sum_carry   (Sum_carry),
        .Data_ready  (Data_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_carry   (res_carry),
        .res_err     (res_err),
        .res_timeout (res_timeout),
        .txn_count   (txn_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count Data_val cycles
    always @(negedge clk) begin
        if (Data_val === 1'b1) dv_count++;
    end

    // behavioural adder responder
    initial begin : adder_model
        logic [8:0] sum9;
        Data_ready = 1'b0;
        Sum_result = '0;
        Sum_carry  = 1'b0;
        forever begin
            @(negedge clk);
            if (Data_val === 1'b1 && rsp_delay >= 0) begin
                repeat (rsp_delay) @(posedge clk);
                @(posedge clk); #1;
                sum9 = {1'b0, Value_a} + {1'b0, Value_b} + fault_add;
                {Sum_carry, Sum_result} = sum9;
                Data_ready = 1'b1;
                @(posedge clk); #1;
                Data_ready = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand pair, then wait for res_valid. lat counts edges
    // from the accepting edge to the edge that raised res_valid.
    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           output int lat);
        bit done;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (op_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        if (!done) check({tag, "_accept_bound"}, 0, 1);
        check({tag, "_data_val"}, Data_val, 1);
        check({tag, "_value_a"}, Value_a, a);
        check({tag, "_value_b"}, Value_b, b);
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            lat++;
            if (res_valid) done = 1'b1;
        end
        if (!done) check({tag, "_res_valid_bound"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_ready"},    op_ready,    1);
        check({tag, "_data_val"},    Data_val,    0);
        check({tag, "_res_valid"},   res_valid,   0);
        check({tag, "_value_a"},     Value_a,     0);
        check({tag, "_value_b"},     Value_b,     0);
        check({tag, "_res_sum"},     res_sum,     0);
        check({tag, "_res_err"},     res_err,     0);
        check({tag, "_res_timeout"}, res_timeout, 0);
        check({tag, "_txn_count"},   txn_count,   0);
        check({tag, "_err_count"},   err_count,   0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        int dv0;

        reset     = 1'b1;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // basic transaction 0x12 + 0x34
        res_ready = 1'b1;
        dv0 = dv_count;
        run_txn("t1", 8'h12, 8'h34, lat);
        check("t1_latency",   lat,       2);
        check("t1_res_sum",   res_sum,   8'h46);
        check("t1_res_carry", res_carry, 0);
        check("t1_res_err",   res_err,   0);
        check("t1_op_ready",  op_ready,  0);
        @(posedge clk); #1;
        check("t1_dv_pulses", dv_count - dv0, 1);
        check("t1_res_valid_drop", res_valid, 0);
        check("t1_op_ready_back",  op_ready,  1);
        check("t1_txn_count", txn_count, 1);
        check("t1_err_count", err_count, 0);

        // carry out
        run_txn("t2a", 8'hFF, 8'h01, lat);
        check("t2a_res_sum",   res_sum,   8'h00);
        check("t2a_res_carry", res_carry, 1);
        check("t2a_res_err",   res_err,   0);
        @(posedge clk); #1;
        run_txn("t2b", 8'h80, 8'h80, lat);
        check("t2b_res_sum",   res_sum,   8'h00);
        check("t2b_res_carry", res_carry, 1);
        check("t2b_res_err",   res_err,   0);
        @(posedge clk); #1;
        check("t2_txn_count", txn_count, 3);
        check("t2_err_count", err_count, 0);

        // faulty adder returns 0x47 for 0x12 + 0x34
        fault_add = 9'd1;
        res_ready = 1'b0;
        run_txn("t3", 8'h12, 8'h34, lat);
        fault_add = 9'd0;
        check("t3_res_sum", res_sum, 8'h47);
        check("t3_res_err", res_err, 1);
        @(posedge clk); #1;
        check("t3_err_count_held", err_count, 0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_err_count", err_count, 1);
        check("t3_txn_count", txn_count, 4);

        // adder never answers: timeout after exactly 4 WAIT cycles
        rsp_delay = -1;
        dv0 = dv_count;
        run_txn("t4", 8'h0F, 8'h0F, lat);
        check("t4_latency",    lat,         5);
        check("t4_res_timeout", res_timeout, 1);
        check("t4_res_err",    res_err,     0);
        check("t4_res_sum",    res_sum,     0);
        check("t4_res_carry",  res_carry,   0);
        @(posedge clk); #1;
        check("t4_dv_pulses",  dv_count - dv0, 1);
        check("t4_err_count",  err_count, 2);
        check("t4_txn_count",  txn_count, 5);

        // Data_ready on the last WAIT cycle still wins
        rsp_delay = 3;
        run_txn("t5", 8'h01, 8'h02, lat);
        rsp_delay = 0;
        check("t5_latency",     lat,         5);
        check("t5_res_timeout", res_timeout, 0);
        check("t5_res_sum",     res_sum,     8'h03);
        check("t5_res_err",     res_err,     0);
        @(posedge clk); #1;
        check("t5_err_count", err_count, 2);
        check("t5_txn_count", txn_count, 6);

        // back-pressure in RESP; new operands must be ignored
        res_ready = 1'b0;
        run_txn("t6", 8'h55, 8'h0A, lat);
        op_a     = 8'h99;
        op_b     = 8'h11;
        op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t6_res_valid_hold", res_valid, 1);
            check("t6_res_sum_hold",   res_sum,   8'h5F);
            check("t6_op_ready_low",   op_ready,  0);
            check("t6_value_a_hold",   Value_a,   8'h55);
        end
        check("t6_txn_count_held", txn_count, 6);
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("t6_res_valid_drop", res_valid, 0);
        check("t6_op_ready_back",  op_ready,  1);
        check("t6_txn_count",      txn_count, 7);
        check("t6_err_count",      err_count, 2);
        @(posedge clk); #1;
        check("t6_txn_count_once", txn_count, 7);

        // reset asserted while in WAIT
        rsp_delay = -1;
        op_a      = 8'h77;
        op_b      = 8'h01;
        op_valid  = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("t7_in_drive", Data_val, 1);
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("t7_rst");
        @(posedge clk); #1;
        reset     = 1'b0;
        rsp_delay = 0;
        @(posedge clk); #1;
        run_txn("t7", 8'h20, 8'h22, lat);
        check("t7_latency", lat,     2);
        check("t7_res_sum", res_sum, 8'h42);
        check("t7_res_err", res_err, 0);
        @(posedge clk); #1;
        check("t7_txn_count", txn_count, 1);
        check("t7_err_count", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
